alu_issue_stage: RTL and testbench

Two-stage issue/retire pipeline wrapped around the combinational 32-bit ALU. Accepts register-addressed instructions over a valid/ready handshake, reads operands from an internal register file with full forwarding, drives the ALU operand/opcode inputs from a pipeline register, and captures the result and flags into a retire register. The retire register writes back to the register file and is presented downstream as a result stream.

---
 rtl/alu_issue_stage.sv | 150 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage issue/retire pipeline around an external
// combinational 32-bit ALU.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   instr_valid / instr_ready   instruction handshake
//   instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_use_imm, instr_imm
//                               instruction fields (register-addressed)
//   operandA, operandB, opcode  ALU inputs, driven from the EX register
//   result, zero_flag, carry_out
//                               ALU outputs, captured into the RET register
//   res_valid / res_ready       retire stream handshake
//   res_rd, res_data            retiring destination and value
//   flag_zero, flag_carry       sticky flags of the last retired instruction
module alu_issue_stage #(
    parameter int  NUM_REGS = 8,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_opcode,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic          instr_use_imm,
    input  logic [31:0]   instr_imm,
    output logic [31:0]   operandA,
    output logic [31:0]   operandB,
    output logic [2:0]    opcode,
    input  logic [31:0]   result,
    input  logic          zero_flag,
    input  logic          carry_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_rd,
    output logic [31:0]   res_data,
    output logic          flag_zero,
    output logic          flag_carry
);

    localparam int DATA_W = 32;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              vld_p1;
    logic [DATA_W-1:0] op_a_p1;
    logic [DATA_W-1:0] op_b_p1;
    logic [2:0]        opc_p1;
    logic [AW-1:0]     rd_p1;

    logic              vld_p2;
    logic [AW-1:0]     rd_p2;
    logic [DATA_W-1:0] data_p2;
    logic              zero_p2;
    logic              carry_p2;

    logic              adv_p1;
    logic              adv_p2;
    logic              accept;
    logic              retire;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;

    // Youngest producer wins: EX result first, then the RET value (even when it
    // retires on this same edge, its regfile write is not yet visible).
    function automatic logic [DATA_W-1:0] read_src(input logic [AW-1:0] rs);
        if (rs == '0)
            return '0;
        else if (vld_p1 && rd_p1 == rs)
            return result;
        else if (vld_p2 && rd_p2 == rs)
            return data_p2;
        else
            return regs[rs];
    endfunction

    assign adv_p2      = !vld_p2 || res_ready;
    assign adv_p1      = !vld_p1 || adv_p2;
    assign instr_ready = adv_p1 && !reset;
    assign accept      = instr_valid && instr_ready;
    assign retire      = vld_p2 && res_ready;

    always_comb begin
        src_a = read_src(instr_rs1);
        src_b = instr_use_imm ? instr_imm : read_src(instr_rs2);
    end

    // ---- issue -> EX (p1) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            op_a_p1 <= '0;
            op_b_p1 <= '0;
            opc_p1  <= '0;
            rd_p1   <= '0;
        end else if (adv_p1) begin
            vld_p1 <= accept;
            if (accept) begin
                op_a_p1 <= src_a;
                op_b_p1 <= src_b;
                opc_p1  <= instr_opcode;
                rd_p1   <= instr_rd;
            end
        end
    end

    // ---- EX -> RET (p2) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            rd_p2    <= '0;
            data_p2  <= '0;
            zero_p2  <= 1'b0;
            carry_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                rd_p2    <= rd_p1;
                data_p2  <= result;
                zero_p2  <= zero_flag;
                carry_p2 <= carry_out;
            end
        end
    end

    // ---- RET -> register file / flags ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else if (retire) begin
            if (rd_p2 != '0)
                regs[rd_p2] <= data_p2;
            flag_zero  <= zero_p2;
            flag_carry <= carry_p2;
        end
    end

    assign operandA  = op_a_p1;
    assign operandB  = op_b_p1;
    assign opcode    = opc_p1;
    assign res_valid = vld_p2;
    assign res_rd    = rd_p2;
    assign res_data  = data_p2;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed bench for alu_issue_stage. A behavioural ALU
// closes the loop between operandA/operandB/opcode and result/flags. One table
// row describes one clock cycle: the inputs driven in that cycle and the
// outputs expected while they are applied.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_opcode = '0;
    logic [2:0]  instr_rd = '0;
    logic [2:0]  instr_rs1 = '0;
    logic [2:0]  instr_rs2 = '0;
    logic        instr_use_imm = 1'b0;
    logic [31:0] instr_imm = '0;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [2:0]  opcode;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [2:0]  res_rd;
    logic [31:0] res_data;
    logic        flag_zero;
    logic        flag_carry;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.NUM_REGS(8)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
        .operandA(operandA), .operandB(operandB), .opcode(opcode),
        .result(alu_result), .zero_flag(alu_zero), .carry_out(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_rd(res_rd), .res_data(res_data),
        .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    // ALU model: carry is carry-out for add, borrow for sub.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (opcode)
            3'b000: {alu_carry, alu_result} = {1'b0, operandA} + {1'b0, operandB};
            3'b001: begin
                alu_result = operandA - operandB;
                alu_carry  = operandA < operandB;
            end
            3'b010: alu_result = operandA & operandB;
            3'b011: alu_result = operandA | operandB;
            3'b100: alu_result = operandA ^ operandB;
            default: ;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        ui;
        logic [31:0] imm;
        logic        rr;
        logic        e_ir;
        logic        e_rv;
        logic [31:0] e_data;
        logic [2:0]  e_rd;
        logic        e_fz;
        logic        e_fc;
    } vec_t;

    localparam int NV = 37;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic vld, input logic [2:0] op, input logic [2:0] rd,
                                input logic [2:0] rs1, input logic [2:0] rs2, input logic ui,
                                input logic [31:0] imm, input logic rr, input logic ir,
                                input logic rv, input logic [31:0] data, input logic [2:0] rrd,
                                input logic fz, input logic fc);
        vec_t v;
        v.vld = vld; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.ui = ui;
        v.imm = imm; v.rr = rr; v.e_ir = ir; v.e_rv = rv; v.e_data = data;
        v.e_rd = rrd; v.e_fz = fz; v.e_fc = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic drive(input logic vld, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic ui,
                         input logic [31:0] imm);
        instr_valid = vld; instr_opcode = op; instr_rd = rd;
        instr_rs1 = rs1; instr_rs2 = rs2; instr_use_imm = ui; instr_imm = imm;
    endtask

    initial begin
        //                vld op rd rs1 rs2 ui imm           rr | ir rv data          rd fz fc
        // dependent chain through forwarding
        tbl[0]  = mk(1, 0, 1, 0, 0, 1, 32'h0A,       1, 1, 0, 32'h0,        0, 0, 0);
        tbl[1]  = mk(1, 0, 2, 0, 0, 1, 32'h05,       1, 1, 0, 32'h0,        0, 0, 0);
        tbl[2]  = mk(1, 1, 3, 1, 2, 0, 32'h0,        1, 1, 1, 32'h0A,       1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h05,       2, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h05,       3, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
        // back-to-back r1 doubling
        tbl[6]  = mk(1, 0, 1, 0, 0, 1, 32'h07,       1, 1, 0, 32'h0,        0, 0, 0);
        tbl[7]  = mk(1, 0, 1, 1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
        tbl[8]  = mk(1, 0, 1, 1, 1, 0, 32'h0,        1, 1, 1, 32'h07,       1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h0E,       1, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h1C,       1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
        // carry / zero, then xor clears carry
        tbl[12] = mk(1, 0, 1, 0, 0, 1, 32'hFFFFFFFF, 1, 1, 0, 32'h0,        0, 0, 0);
        tbl[13] = mk(1, 0, 2, 0, 0, 1, 32'h1,        1, 1, 0, 32'h0,        0, 0, 0);
        tbl[14] = mk(1, 0, 3, 1, 2, 0, 32'h0,        1, 1, 1, 32'hFFFFFFFF, 1, 0, 0);
        tbl[15] = mk(1, 4, 3, 1, 1, 0, 32'h0,        1, 1, 1, 32'h1,        2, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        3, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        3, 1, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 1, 0);
        // r0 writes ignored, undefined opcode
        tbl[19] = mk(1, 0, 0, 0, 0, 1, 32'h55,       1, 1, 0, 32'h0,        0, 1, 0);
        tbl[20] = mk(1, 0, 4, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 1, 0);
        tbl[21] = mk(1, 7, 5, 1, 0, 1, 32'h3,        1, 1, 1, 32'h55,       0, 1, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        4, 0, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        5, 1, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 1, 0);
        // backpressure: res_ready low for three cycles
        tbl[25] = mk(1, 0, 1, 0, 0, 1, 32'h1,        1, 1, 0, 32'h0,        0, 1, 0);
        tbl[26] = mk(1, 0, 2, 0, 0, 1, 32'h2,        0, 1, 0, 32'h0,        0, 1, 0);
        tbl[27] = mk(1, 0, 3, 0, 0, 1, 32'h3,        0, 0, 1, 32'h1,        1, 1, 0);
        tbl[28] = mk(1, 0, 3, 0, 0, 1, 32'h3,        0, 0, 1, 32'h1,        1, 1, 0);
        tbl[29] = mk(1, 0, 3, 0, 0, 1, 32'h3,        1, 1, 1, 32'h1,        1, 1, 0);
        tbl[30] = mk(1, 0, 4, 0, 0, 1, 32'h4,        1, 1, 1, 32'h2,        2, 0, 0);
        tbl[31] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h3,        3, 0, 0);
        tbl[32] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h4,        4, 0, 0);
        // regfile contents after the stalled stream
        tbl[33] = mk(1, 0, 5, 1, 4, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
        tbl[34] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
        tbl[35] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h5,        5, 0, 0);
        tbl[36] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk1("rst instr_ready", instr_ready, 1'b0);
        chk1("rst res_valid", res_valid, 1'b0);
        chk("rst operandA", operandA, 32'h0);
        chk("rst res_data", res_data, 32'h0);
        chk1("rst flag_zero", flag_zero, 1'b0);
        chk1("rst flag_carry", flag_carry, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].vld, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].ui, tbl[i].imm);
            res_ready = tbl[i].rr;
            #1;
            chk1($sformatf("row%0d instr_ready", i), instr_ready, tbl[i].e_ir);
            chk1($sformatf("row%0d res_valid", i), res_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                chk($sformatf("row%0d res_data", i), res_data, tbl[i].e_data);
                chk($sformatf("row%0d res_rd", i), {29'b0, res_rd}, {29'b0, tbl[i].e_rd});
            end
            chk1($sformatf("row%0d flag_zero", i), flag_zero, tbl[i].e_fz);
            chk1($sformatf("row%0d flag_carry", i), flag_carry, tbl[i].e_fc);
        end

        // reset with two instructions in flight
        @(negedge clk);
        drive(1, 3'b001, 3'd6, 3'd0, 3'd0, 1, 32'h1);   // r6 <- 0 - 1 (borrow)
        res_ready = 1'b1;
        @(negedge clk);
        drive(1, 3'b000, 3'd7, 3'd0, 3'd0, 1, 32'h77);  // r7 <- 0x77
        @(negedge clk);
        drive(0, 3'b000, 3'd0, 3'd0, 3'd0, 0, 32'h0);
        reset = 1'b1;
        #1;
        chk1("midrst instr_ready", instr_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("postrst res_valid", res_valid, 1'b0);
        chk1("postrst instr_ready", instr_ready, 1'b1);
        chk1("postrst flag_zero", flag_zero, 1'b0);
        chk1("postrst flag_carry", flag_carry, 1'b0);
        chk("postrst operandB", operandB, 32'h0);
        chk("postrst opcode", {29'b0, opcode}, 32'h0);
        chk("postrst res_data", res_data, 32'h0);
        drive(1, 3'b000, 3'd1, 3'd1, 3'd6, 0, 32'h0);   // r1 + r6, both cleared
        @(negedge clk);
        drive(1, 3'b011, 3'd2, 3'd7, 3'd5, 0, 32'h0);   // r7 | r5, both cleared
        @(negedge clk);
        drive(0, 3'b000, 3'd0, 3'd0, 3'd0, 0, 32'h0);
        #1;
        chk1("postrst rv A", res_valid, 1'b1);
        chk("postrst data A", res_data, 32'h0);
        @(negedge clk);
        #1;
        chk1("postrst rv B", res_valid, 1'b1);
        chk("postrst data B", res_data, 32'h0);
        chk1("postrst fz A", flag_zero, 1'b1);
        @(negedge clk);
        #1;
        chk1("postrst rv end", res_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
